// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular receive buffer behind the UART receiver.
// Bytes are captured from one-cycle in_valid strobes and presented to the
// consumer as a first-word-fall-through ready/valid stream, with fill level
// and a sticky overrun flag for bytes dropped while the buffer was full.
//
// Handshake: a word transfers on any rising edge where out_valid and
// out_ready are both high. out_valid depends only on registered state, never
// on out_ready. The producer has no back-pressure. in_valid is a strobe that
// is either accepted or counted as an overrun.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          empty,
    output logic                          full,
    output logic                          overrun,
    input  logic                          clr_overrun
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    // Storage has no reset. Stale contents are never visible because
    // out_data is masked whenever the FIFO is empty.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              overrun_q, overrun_d;

    logic is_empty;
    logic is_full;
    logic do_pop;
    logic do_push;
    logic drop;

    // Status flags derived purely from the registered occupancy count
    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == FULL_CNT);
    end

    // Transfer decisions for this cycle. A pop frees a slot, so a write into
    // a full FIFO is still accepted when the head leaves in the same cycle.
    always_comb begin
        do_pop  = !is_empty && out_ready;
        do_push = in_valid && (!is_full || do_pop);
        drop    = in_valid && is_full && !do_pop;
    end

    // Next-state for pointers, occupancy and the sticky overrun flag
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        // Pointers are exactly ADDR_W wide, so the increment wraps at DEPTH.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new drop outranks a simultaneous clear so no loss goes unreported.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // Control state register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage write port
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Output drive: head word falls through, zeroed while empty
    always_comb begin
        out_valid = !is_empty;
        out_data  = is_empty ? '0 : mem_q[rd_ptr_q];
        count     = count_q;
        empty     = is_empty;
        full      = is_full;
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. The reference model is a byte queue
// plus an overrun bit. A behavioural serial receiver feeds the FIFO for the
// UART integration scenario.
module tb_uart_rx_fifo;

    localparam int DW      = 8;
    localparam int DEPTH   = 16;
    localparam int AW      = $clog2(DEPTH);
    localparam int BIT_CYC = 868;   // 100 MHz / 115200 baud

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [DW-1:0] drv_data = '0;
    logic          drv_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_overrun = 1'b0;
    logic          use_uart = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_line = 1'b1;

    logic [DW-1:0] in_data;
    logic          in_valid;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          overrun;

    assign in_data  = use_uart ? rx_data  : drv_data;
    assign in_valid = use_uart ? rx_valid : drv_valid;

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic          exp_ovr = 1'b0;
    logic [DW-1:0] last_pop = '0;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_count"},  32'(count),     32'(exp_q.size()));
        chk({tag, "_empty"},  32'(empty),     32'(exp_q.size() == 0));
        chk({tag, "_full"},   32'(full),      32'(exp_q.size() == DEPTH));
        chk({tag, "_valid"},  32'(out_valid), 32'(exp_q.size() != 0));
        chk({tag, "_data"},   32'(out_data),  (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
        chk({tag, "_ovr"},    32'(overrun),   32'(exp_ovr));
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: checks outputs, applies inputs for one cycle,
    // advances the model by the rules of one rising edge, returns at the next
    // falling edge with inputs idle.
    task automatic step(input string tag, input bit iv, input logic [DW-1:0] d,
                        input bit rdy, input bit clr);
        bit m_pop;
        bit m_full;
        check_outputs(tag);
        drv_valid   = iv;
        drv_data    = d;
        out_ready   = rdy;
        clr_overrun = clr;
        m_pop  = rdy && (exp_q.size() != 0);
        m_full = (exp_q.size() == DEPTH);
        if (m_pop) last_pop = exp_q.pop_front();
        if (iv && (!m_full || m_pop)) exp_q.push_back(d);
        if (iv && m_full && !m_pop) exp_ovr = 1'b1;
        else if (clr)               exp_ovr = 1'b0;
        @(negedge clk);
        drv_valid   = 1'b0;
        out_ready   = 1'b0;
        clr_overrun = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 4 * DEPTH) begin
            step(tag, 1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        check_outputs({tag, "_end"});
    endtask

    // Serial line driver, changes on falling edges
    task automatic uart_send(input logic [DW-1:0] b);
        rx_line = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            rx_line = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    // Behavioural UART receiver: mid-bit sampling, valid pulse at mid stop bit
    initial begin
        forever begin
            @(negedge rx_line);
            repeat (BIT_CYC / 2) @(posedge clk);
            if (rx_line == 1'b0) begin
                for (int i = 0; i < DW; i++) begin
                    repeat (BIT_CYC) @(posedge clk);
                    rx_data[i] = rx_line;
                end
                repeat (BIT_CYC) @(posedge clk);
                #1 rx_valid = 1'b1;
                @(posedge clk);
                #1 rx_valid = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int pushes;
        int guard;
        bit iv;
        logic [DW-1:0] d;

        // Reset state
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full",  32'(full), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ovr",   32'(overrun), 0);
        chk("rst_data",  32'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: three pushes, then read in order
        step("t1", 1'b1, 8'h11, 1'b0, 1'b0);
        chk("t1_head", 32'(out_data), 32'h11);
        chk("t1_vld",  32'(out_valid), 1);
        step("t1", 1'b1, 8'h22, 1'b0, 1'b0);
        step("t1", 1'b1, 8'h33, 1'b0, 1'b0);
        chk("t1_cnt3", 32'(count), 3);
        step("t1r", 1'b0, '0, 1'b1, 1'b0);
        chk("t1_2nd", 32'(out_data), 32'h22);
        step("t1r", 1'b0, '0, 1'b1, 1'b0);
        chk("t1_3rd", 32'(out_data), 32'h33);
        step("t1r", 1'b0, '0, 1'b1, 1'b0);
        chk("t1_empty", 32'(empty), 1);
        chk("t1_zero",  32'(out_data), 0);
        // pop request while empty must not move anything
        step("t1e", 1'b0, '0, 1'b1, 1'b0);
        chk("t1e_cnt", 32'(count), 0);

        // 2: fill, overrun, drain, clear
        for (int i = 0; i < DEPTH; i++) step("t2f", 1'b1, 8'(i), 1'b0, 1'b0);
        chk("t2_full", 32'(full), 1);
        chk("t2_cnt",  32'(count), 16);
        step("t2o", 1'b1, 8'hAA, 1'b0, 1'b0);
        chk("t2_ovr",  32'(overrun), 1);
        chk("t2_cnt2", 32'(count), 16);
        // simultaneous clear and new drop: the drop wins
        step("t2s", 1'b1, 8'hBB, 1'b0, 1'b1);
        chk("t2_setwin", 32'(overrun), 1);
        drain("t2d");
        chk("t2_last", 32'(last_pop), 32'h0F);
        step("t2c", 1'b0, '0, 1'b0, 1'b1);
        chk("t2_clr", 32'(overrun), 0);

        // 3: full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) step("t3f", 1'b1, 8'(i), 1'b0, 1'b0);
        step("t3x", 1'b1, 8'h5A, 1'b1, 1'b0);
        chk("t3_ovr",  32'(overrun), 0);
        chk("t3_cnt",  32'(count), 16);
        chk("t3_head", 32'(out_data), 32'h01);
        drain("t3d");
        chk("t3_last", 32'(last_pop), 32'h5A);

        // 4: random interleave, at least 40 accepted pushes
        pushes = 0;
        guard  = 0;
        while (pushes < 40 && guard < 2000) begin
            iv = ($urandom_range(0, 99) < 60);
            d  = 8'($urandom_range(0, 255));
            if (iv && (exp_q.size() < DEPTH)) pushes++;
            step("t4", iv, d, 1'($urandom_range(0, 1)), 1'b0);
            guard++;
        end
        chk("t4_pushes", 32'(pushes >= 40), 1);
        drain("t4d");
        if (exp_ovr) step("t4c", 1'b0, '0, 1'b0, 1'b1);

        // 5: asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) step("t5f", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        chk("t5_cnt5", 32'(count), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_cnt",   32'(count), 0);
        chk("t5_empty", 32'(empty), 1);
        chk("t5_valid", 32'(out_valid), 0);
        chk("t5_ovr",   32'(overrun), 0);
        exp_q.delete();
        exp_ovr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step("t5p", 1'b1, 8'h77, 1'b0, 1'b0);
        chk("t5_first", 32'(out_data), 32'h77);
        drain("t5d");

        // 6: serial integration through the behavioural receiver
        use_uart = 1'b1;
        uart_send(8'h55);
        uart_send(8'hFF);
        repeat (4) @(negedge clk);
        chk("t6_cnt", 32'(count), 2);
        use_uart = 1'b0;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hFF);
        chk("t6_first", 32'(out_data), 32'h55);
        step("t6r", 1'b0, '0, 1'b1, 1'b0);
        chk("t6_second", 32'(out_data), 32'hFF);
        drain("t6d");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
